// File: rtl/wb_master_adapter.sv
// wb_master_adapter: Wishbone classic master that turns one byte/half/word load/store into a single bus cycle
//  request side : clk_i, rst_i, req_i, we_i, addr_i, wdata_i, size_i, unsigned_i -> ready_o, done_o, err_o, rdata_o
//  bus side     : wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o <- wb_dat_i, wb_ack_i
module wb_master_adapter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 1023
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [1:0]            size_i,
  input  logic                  unsigned_i,
  output logic                  ready_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  output logic [3:0]            wb_sel_o,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  input  logic                  wb_ack_i
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic r_we, r_uns, r_err;
  logic [1:0] r_size, r_off;
  logic [ADDR_WIDTH-1:0] r_adr;
  logic [DATA_WIDTH-1:0] r_dat, r_rdata;
  logic [3:0] r_sel;
  logic w_bad, w_acc, w_ack, w_to;
  logic [3:0] w_sel;
  logic [DATA_WIDTH-1:0] w_mask, w_ext;
  logic [15:0] w_lane;
  assign w_bad = size_i == 2'd3 || (size_i == 2'd1 && addr_i[0]) || (size_i == 2'd2 && addr_i[1:0] != 2'd0);
  assign w_acc = r_state == IDLE && req_i;
  assign w_ack = r_state == BUSY && wb_ack_i;
  // the count is compared one short so the bus is held for exactly TIMEOUT cycles; ack takes priority
  assign w_to = TIMEOUT != 0 && r_state == BUSY && !wb_ack_i && r_cnt == LAST;
  assign w_sel = size_i == 2'd0 ? 4'b0001 << addr_i[1:0] : size_i == 2'd1 ? 4'b0011 << addr_i[1:0] : 4'b1111;
  assign w_mask = {{8{w_sel[3]}}, {8{w_sel[2]}}, {8{w_sel[1]}}, {8{w_sel[0]}}};
  assign w_lane = 16'(wb_dat_i >> {r_off, 3'b000});
  assign w_ext = r_size == 2'd0 ? {{24{!r_uns && w_lane[7]}}, w_lane[7:0]} :
                 r_size == 2'd1 ? {{16{!r_uns && w_lane[15]}}, w_lane} : wb_dat_i;
  always_ff @(posedge clk_i) r_state <= rst_i ? IDLE : w_next;
  always_comb begin
    w_next = r_state == IDLE ? (req_i ? (w_bad ? DONE : BUSY) : IDLE) :
             r_state == BUSY ? (wb_ack_i || w_to ? DONE : BUSY) : IDLE;
    ready_o = r_state == IDLE;
    done_o = r_state == DONE;
    err_o = r_state == DONE && r_err;
    wb_cyc_o = r_state == BUSY;
    wb_stb_o = r_state == BUSY;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
      r_we <= 1'b0;
      r_uns <= 1'b0;
      r_err <= 1'b0;
      r_size <= 2'd0;
      r_off <= 2'd0;
      r_adr <= '0;
      r_dat <= '0;
      r_sel <= 4'd0;
      r_rdata <= '0;
    end else begin
      if (w_acc) r_err <= w_bad;
      if (w_acc && !w_bad) begin
        r_cnt <= '0;
        r_we <= we_i;
        r_uns <= unsigned_i;
        r_size <= size_i;
        r_off <= addr_i[1:0];
        r_adr <= addr_i;
        r_dat <= (wdata_i << {addr_i[1:0], 3'b000}) & w_mask;
        r_sel <= w_sel;
      end
      if (r_state == BUSY) begin
        r_cnt <= r_cnt + 1'b1;
        r_err <= w_to;
      end
      if (w_ack && !r_we) r_rdata <= w_ext;
    end
  end
  assign rdata_o = r_rdata;
  assign wb_we_o = r_we;
  assign wb_adr_o = r_adr;
  assign wb_dat_o = r_dat;
  assign wb_sel_o = r_sel;
endmodule

// File: tb/tb_wb_master_adapter.sv
// tb_wb_master_adapter: directed and randomized transactions checked every cycle against a transaction-level model
module tb_wb_master_adapter;
  localparam int T = 8;
  logic clk_i = 1'b0;
  logic rst_i, req_i, we_i, unsigned_i, wb_ack_i;
  logic [31:0] addr_i, wdata_i, wb_dat_i;
  logic [1:0] size_i;
  logic ready_o, done_o, err_o, wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] rdata_o, wb_adr_o, wb_dat_o;
  logic [3:0] wb_sel_o;
  int vectors = 0, miscompares = 0;
  logic chk = 1'b0;
  logic e_ready, e_done, e_err, e_cyc, e_we;
  logic [31:0] e_rdata, e_adr, e_dat;
  logic [3:0] e_sel;
  wb_master_adapter #(.TIMEOUT(T)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .size_i(size_i), .unsigned_i(unsigned_i), .ready_o(ready_o), .done_o(done_o), .err_o(err_o),
    .rdata_o(rdata_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk1(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int m_bytes(logic [1:0] sz);
    return 1 << sz;
  endfunction
  function automatic logic m_legal(logic [1:0] sz, logic [1:0] o);
    return sz != 2'd3 && (int'(o) % m_bytes(sz)) == 0;
  endfunction
  function automatic logic [3:0] m_sel(logic [1:0] sz, logic [1:0] o);
    logic [3:0] s = 4'd0;
    for (int i = 0; i < m_bytes(sz); i++) s[int'(o) + i] = 1'b1;
    return s;
  endfunction
  function automatic logic [31:0] m_dat(logic [1:0] sz, logic [1:0] o, logic [31:0] wd);
    logic [3:0] s = m_sel(sz, o);
    logic [31:0] v = 32'd0;
    for (int i = 0; i < 4; i++) if (s[i]) v[8*i +: 8] = wd[8*(i - int'(o)) +: 8];
    return v;
  endfunction
  function automatic logic [31:0] m_ext(logic [1:0] sz, logic [1:0] o, logic uns, logic [31:0] d);
    logic [31:0] v = d >> (8 * int'(o));
    logic [31:0] m = sz == 2'd0 ? 32'hFF : 32'hFFFF;
    if (sz == 2'd2) return d;
    v = v & m;
    if (!uns && (v & (m ^ (m >> 1))) != 0) v = v | ~m;
    return v;
  endfunction
  always @(negedge clk_i) if (chk) begin
    chk1("ready", ready_o, e_ready);
    chk1("done", done_o, e_done);
    chk1("err", err_o, e_err);
    chk1("cyc", wb_cyc_o, e_cyc);
    chk1("stb", wb_stb_o, e_cyc);
    chk1("rdata", rdata_o, e_rdata);
    if (e_cyc) begin
      chk1("adr", wb_adr_o, e_adr);
      chk1("we", wb_we_o, e_we);
      chk1("sel", wb_sel_o, e_sel);
      if (e_we) chk1("dat_o", wb_dat_o, e_dat);
    end
  end
  task automatic scramble();
    req_i = 1'($urandom);
    we_i = 1'($urandom);
    addr_i = $urandom;
    wdata_i = $urandom;
    size_i = 2'($urandom);
    unsigned_i = 1'($urandom);
  endtask
  task automatic idle_cycle();
    scramble();
    req_i = 1'b0;
    wb_ack_i = 1'($urandom);
    wb_dat_i = $urandom;
    e_ready = 1'b1; e_done = 1'b0; e_err = 1'b0; e_cyc = 1'b0;
    @(posedge clk_i); #1;
  endtask
  task automatic txn(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz,
                     input logic uns, input int d, input logic [31:0] rd);
    logic bad = !m_legal(sz, a[1:0]);
    req_i = 1'b1; we_i = we; addr_i = a; wdata_i = wd; size_i = sz; unsigned_i = uns;
    wb_ack_i = 1'b0; wb_dat_i = $urandom;
    e_ready = 1'b1; e_done = 1'b0; e_err = 1'b0; e_cyc = 1'b0;
    @(posedge clk_i); #1;
    scramble();
    e_ready = 1'b0;
    if (bad) e_err = 1'b1;
    else begin
      e_cyc = 1'b1; e_adr = a; e_we = we; e_sel = m_sel(sz, a[1:0]); e_dat = m_dat(sz, a[1:0], wd);
      for (int k = 0; k < T; k++) begin
        wb_ack_i = (k == d);
        wb_dat_i = (k == d) ? rd : $urandom;
        @(posedge clk_i); #1;
        if (k == d) break;
      end
      e_cyc = 1'b0;
      wb_ack_i = 1'($urandom);
      wb_dat_i = $urandom;
      e_err = d >= T;
      if (d < T && !we) e_rdata = m_ext(sz, a[1:0], uns, rd);
    end
    e_done = 1'b1;
    @(posedge clk_i); #1;
    e_done = 1'b0; e_err = 1'b0; e_ready = 1'b1;
  endtask
  initial begin
    rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0; size_i = 2'd0; unsigned_i = 1'b0;
    wb_ack_i = 1'b1; wb_dat_i = 32'hFFFF_FFFF;
    e_ready = 1'b1; e_done = 1'b0; e_err = 1'b0; e_cyc = 1'b0; e_we = 1'b0;
    e_rdata = 32'd0; e_adr = 32'd0; e_dat = 32'd0; e_sel = 4'd0;
    repeat (2) @(posedge clk_i);
    #1;
    chk = 1'b1;
    chk1("rst_adr", wb_adr_o, 32'd0);
    chk1("rst_dat", wb_dat_o, 32'd0);
    chk1("rst_sel", wb_sel_o, 32'd0);
    chk1("rst_we", wb_we_o, 32'd0);
    rst_i = 1'b0; wb_ack_i = 1'b0;
    chk1("pin_sel_b1", m_sel(2'd0, 2'd1), 32'h2);
    chk1("pin_sel_h2", m_sel(2'd1, 2'd2), 32'hC);
    chk1("pin_dat_h2", m_dat(2'd1, 2'd2, 32'h1234_BEEF), 32'hBEEF_0000);
    chk1("pin_ext_sb", m_ext(2'd0, 2'd1, 1'b0, 32'h8080_8080), 32'hFFFF_FF80);
    chk1("pin_ext_uh", m_ext(2'd1, 2'd2, 1'b1, 32'h8001_0000), 32'h0000_8001);
    idle_cycle();
    txn(1'b0, 32'h8000_0004, 32'h0, 2'd2, 1'b0, 2, 32'hDEAD_BEEF);
    chk1("t1_rdata", rdata_o, 32'hDEAD_BEEF);
    txn(1'b0, 32'h1000_0005, 32'h0, 2'd0, 1'b0, 0, 32'h8080_8080);
    chk1("t2_signed", rdata_o, 32'hFFFF_FF80);
    txn(1'b0, 32'h1000_0005, 32'h0, 2'd0, 1'b1, 1, 32'h8080_8080);
    chk1("t2_unsigned", rdata_o, 32'h0000_0080);
    txn(1'b1, 32'h1000_0000, 32'hFFFF_FF41, 2'd0, 1'b0, 1, 32'h0);
    txn(1'b1, 32'h1000_0002, 32'h1234_BEEF, 2'd1, 1'b0, 0, 32'h0);
    chk1("t3_rdata_kept", rdata_o, 32'h0000_0080);
    txn(1'b0, 32'h1000_0001, 32'h0, 2'd1, 1'b0, 0, 32'h0);
    txn(1'b0, 32'h1000_0000, 32'h0, 2'd3, 1'b0, 0, 32'h0);
    txn(1'b0, 32'h3000_0000, 32'h0, 2'd2, 1'b0, 100, 32'h1111_1111);
    txn(1'b0, 32'h3000_0000, 32'h0, 2'd2, 1'b0, T - 1, 32'h2222_2222);
    chk1("t5_ack_wins", rdata_o, 32'h2222_2222);
    txn(1'b0, 32'h3000_0000, 32'h0, 2'd2, 1'b0, T, 32'h3333_3333);
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h2000_0000; size_i = 2'd2; unsigned_i = 1'b0; wb_ack_i = 1'b0;
    e_ready = 1'b1; e_cyc = 1'b0; e_done = 1'b0; e_err = 1'b0;
    @(posedge clk_i); #1;
    req_i = 1'b0;
    e_ready = 1'b0; e_cyc = 1'b1; e_adr = 32'h2000_0000; e_we = 1'b0; e_sel = 4'hF;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0; wb_ack_i = 1'b1; wb_dat_i = 32'h5555_5555;
    e_ready = 1'b1; e_cyc = 1'b0; e_rdata = 32'd0;
    repeat (2) begin
      @(posedge clk_i); #1;
    end
    chk1("t6_rdata", rdata_o, 32'd0);
    for (int n = 0; n < 300; n++) begin
      repeat ($urandom_range(0, 2)) idle_cycle();
      txn(1'($urandom), $urandom, $urandom, 2'($urandom), 1'($urandom), int'($urandom_range(0, 10)), $urandom);
    end
    idle_cycle();
    idle_cycle();
    chk = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
